semaforo_seq: RTL and testbench

- Traffic-light sequencer for a four-approach intersection. It drives the 12-bit `semaforos` lamp bus, which the on-chip analyzer probes, on the same `clk` domain.
- Grants green to one approach at a time, round-robin among approaches with a pending vehicle request, with timed green, yellow and all-red clearance phases.
- Supports an emergency override that forces the intersection to all-red.

---
 rtl/semaforo_seq.sv | 140 ++++++++++++++
 tb/tb_semaforo_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/semaforo_seq.sv
// Four-approach traffic-light sequencer: round-robin green grant with timed green/yellow/all-red and emergency all-red.
// Latency: all outputs registered; a decision taken on a tick edge is visible on the outputs the next cycle.
// Backpressure: none; req/emerg are level inputs sampled every clk edge, no handshake.
module semaforo_seq #(
  parameter int TICK_DIV = 27000000,
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic        emerg,
  output logic [11:0] semaforos,
  output logic [1:0]  phase,
  output logic [1:0]  active,
  output logic        tick
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (T_GREEN > T_YELLOW) ? ((T_GREEN > T_ALLRED) ? T_GREEN : T_ALLRED)
                                             : ((T_YELLOW > T_ALLRED) ? T_YELLOW : T_ALLRED);
  // +1 so a power-of-two duration still fits in the timer
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [11:0]   ALL_RED_LAMPS = 12'h924;

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    act_d;
  logic [11:0]   lamps_d;
  logic          expired;
  logic          other_req;
  logic          changed;

  // First requesting approach after 'last', wrapping; 'last' itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign expired   = tick && (tmr_q == TW'(1));
  assign other_req = |(req & ~(4'b0001 << active));

  // Next-state, next grant, prescaler/timer and lamp decode
  always_comb begin
    state_d = state_q;
    act_d   = active;
    lamps_d = ALL_RED_LAMPS;
    pre_d   = '0;
    tmr_d   = tmr_q;

    case (state_q)
      S_ALL_RED: begin
        if (expired && !emerg && (|req)) begin
          state_d = S_GREEN;
          act_d   = rr_pick(active, req);
        end
      end
      S_GREEN: begin
        if (emerg) begin
          state_d = S_YELLOW;
        end else if (expired && other_req) begin
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (expired) begin
          state_d = S_ALL_RED;
        end
      end
      default: begin
        state_d = S_ALL_RED;
      end
    endcase

    changed = (state_d != state_q);

    // Phases are timed from their first cycle, so the prescaler restarts on every change.
    if (!changed && (pre_q != PRE_LAST)) begin
      pre_d = pre_q + 1'b1;
    end

    // Timer saturates at 1 so a held phase re-evaluates at every later tick.
    if (changed) begin
      case (state_d)
        S_GREEN:  tmr_d = TW'(T_GREEN);
        S_YELLOW: tmr_d = TW'(T_YELLOW);
        default:  tmr_d = TW'(T_ALLRED);
      endcase
    end else if (tick && (tmr_q > TW'(1))) begin
      tmr_d = tmr_q - 1'b1;
    end

    if (state_d == S_GREEN) begin
      lamps_d[3*int'(act_d) +: 3] = 3'b001;
    end else if (state_d == S_YELLOW) begin
      lamps_d[3*int'(act_d) +: 3] = 3'b010;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ALL_RED;
      pre_q     <= '0;
      tmr_q     <= TW'(T_ALLRED);
      active    <= 2'd3;
      semaforos <= ALL_RED_LAMPS;
      phase     <= 2'd0;
      tick      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      tmr_q     <= tmr_d;
      active    <= act_d;
      semaforos <= lamps_d;
      phase     <= state_d;
      tick      <= (pre_d == PRE_LAST);
    end
  end

endmodule

// File: tb/tb_semaforo_seq.sv
// Self-checking bench for semaforo_seq: directed scenarios plus random req/emerg/rst against a timeline model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: not applicable.
module tb_semaforo_seq;

  localparam int TD = 4;
  localparam int TG = 3;
  localparam int TY = 2;
  localparam int TA = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic        emerg = 1'b0;
  logic [11:0] semaforos;
  logic [1:0]  phase;
  logic [1:0]  active;
  logic        tick;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference: phase (0 all-red, 1 green, 2 yellow), granted approach, cycles spent in current phase
  int m_state = 0;
  int m_act = 3;
  int m_pc = 0;

  semaforo_seq #(.TICK_DIV(TD), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA)) dut (
    .clk(clk), .rst(rst), .req(req), .emerg(emerg),
    .semaforos(semaforos), .phase(phase), .active(active), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int s);
    if (s == 1) return TG;
    if (s == 2) return TY;
    return TA;
  endfunction

  function automatic logic [11:0] exp_lamps(input int s, input int a);
    logic [11:0] v;
    for (int i = 0; i < 4; i++) begin
      if (i == a && s == 1)      v[3*i +: 3] = 3'b001;
      else if (i == a && s == 2) v[3*i +: 3] = 3'b010;
      else                       v[3*i +: 3] = 3'b100;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // One clock: predict from inputs held this cycle, clock, then compare all outputs.
  task automatic step();
    int  ns, na, npc;
    bit  tk, ex;
    ns = m_state;
    na = m_act;
    tk = (m_pc % TD) == TD - 1;
    ex = tk && ((m_pc / TD + 1) >= dur(m_state));
    if (m_state == 0) begin
      if (ex && !emerg && req != 4'b0000) begin
        ns = 1;
        for (int k = 4; k >= 1; k--) if (req[(m_act + k) % 4]) na = (m_act + k) % 4;
      end
    end else if (m_state == 1) begin
      if (emerg) ns = 2;
      else if (ex && ((req & ~(4'b0001 << m_act)) != 4'b0000)) ns = 2;
    end else begin
      if (ex) ns = 0;
    end
    npc = (ns != m_state) ? 0 : m_pc + 1;
    if (rst) begin
      ns = 0; na = 3; npc = 0;
    end
    @(posedge clk);
    #1;
    cyc = rst ? 0 : cyc + 1;
    m_state = ns; m_act = na; m_pc = npc;
    chk("semaforos", 32'(semaforos), 32'(exp_lamps(m_state, m_act)));
    chk("phase", 32'(phase), 32'(m_state));
    chk("active", 32'(active), 32'(m_act));
    chk("tick", 32'(tick), 32'((m_pc % TD) == TD - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;

    // Scenario 1: single requester, rest-in-green
    req = 4'b0001;
    do_reset();
    chk("rst_lamps", 32'(semaforos), 32'h924);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_active", 32'(active), 3);
    chk("rst_tick", 32'(tick), 0);
    for (int i = 1; i <= 3; i++) step();
    chk("s1_c3_tick", 32'(tick), 1);
    chk("s1_c3_lamps", 32'(semaforos), 32'h924);
    step();
    chk("s1_c4_lamps", 32'(semaforos), 32'h921);
    chk("s1_c4_phase", 32'(phase), 1);
    chk("s1_c4_active", 32'(active), 0);
    while (cyc < 40) step();
    chk("s1_rest_green", 32'(semaforos), 32'h921);

    // Scenario 2: approach 2 joins; hand-over at next tick
    req = 4'b0101;
    while (cyc < 44) step();
    chk("s2_yellow", 32'(semaforos), 32'h922);
    while (cyc < 56) step();
    chk("s2_green2", 32'(semaforos), 32'h864);
    chk("s2_active2", 32'(active), 2);
    for (int i = 0; i < 20; i++) step();

    // Scenario 3: all approaches requesting, two full rotations
    req = 4'b1111;
    do_reset();
    for (int i = 0; i < 200; i++) step();

    // Scenario 4: emergency during green on approach 1
    n = 0;
    while (!(m_state == 1 && m_act == 1 && m_pc == 5) && n < 300) begin
      step();
      n++;
    end
    chk("s4_reach_green1", 32'(n < 300), 1);
    emerg = 1'b1;
    step();
    chk("s4_yellow1", 32'(semaforos), 32'h914);
    for (int i = 1; i < 30; i++) step();
    chk("s4_allred_held", 32'(semaforos), 32'h924);
    emerg = 1'b0;
    for (int i = 0; i < 60; i++) step();

    // Scenario 5: idle, then approach 3 requests
    req = 4'b0000;
    do_reset();
    for (int i = 0; i < 30; i++) step();
    chk("s5_idle_phase", 32'(phase), 0);
    req = 4'b1000;
    n = 0;
    while (phase != 2'd1 && n < 8) begin
      step();
      n++;
    end
    chk("s5_green3", 32'(semaforos), 32'h324);

    // Scenario 6: reset during yellow
    req = 4'b1111;
    n = 0;
    while (m_state != 2 && n < 100) begin
      step();
      n++;
    end
    chk("s6_reach_yellow", 32'(n < 100), 1);
    step();
    req = 4'b0001;
    do_reset();
    chk("s6_lamps", 32'(semaforos), 32'h924);
    chk("s6_phase", 32'(phase), 0);
    chk("s6_active", 32'(active), 3);
    chk("s6_tick", 32'(tick), 0);
    for (int i = 0; i < 20; i++) step();
    chk("s6_restart_green0", 32'(semaforos), 32'h921);

    // Random traffic with occasional emergencies and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) emerg = ~emerg;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
